// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives the synchronous instruction memory address,
// tracks the PC and presents {instruction, pc, valid} to decode one cycle later.
module instruction_fetch #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 64,
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [ADDR_WIDTH-1:0] instruction_address,
  input  logic [DATA_WIDTH-1:0] instruction_data,
  output logic [DATA_WIDTH-1:0] instruction_out,
  output logic [ADDR_WIDTH-1:0] instruction_pc,
  output logic                  instruction_valid
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PC_INIT   = ADDR_WIDTH'(RESET_PC) & ADDR_MASK;

  // MEM_DEPTH is a power of two, so wrapping is a mask of the low bits.
  function automatic logic [ADDR_WIDTH-1:0] wrap_addr(input logic [ADDR_WIDTH-1:0] a);
    return a & ADDR_MASK;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    return wrap_addr(a + ADDR_WIDTH'(1));
  endfunction

  logic [ADDR_WIDTH-1:0] pc_p0;
  logic [ADDR_WIDTH-1:0] pc_p1;
  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] target_p0;

  assign target_p0 = wrap_addr(branch_target);

  // Stage p0: address issued to memory this cycle
  always_comb begin
    instruction_address = pc_p0;
    if (!enable) begin
      instruction_address = pc_p0;
    end else if (branch_taken) begin
      instruction_address = target_p0;
    end else if (stall) begin
      instruction_address = pc_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0  <= PC_INIT;
      pc_p1  <= '0;
      vld_p1 <= 1'b0;
    end else if (!enable) begin
      vld_p1 <= 1'b0;
    end else if (branch_taken) begin
      pc_p1  <= target_p0;
      vld_p1 <= 1'b1;
      pc_p0  <= next_addr(target_p0);
    end else if (!stall) begin
      pc_p1  <= pc_p0;
      vld_p1 <= 1'b1;
      pc_p0  <= next_addr(pc_p0);
    end
  end

  // Stage p1: memory data arrives alongside the registered pc/valid
  assign instruction_out   = instruction_data;
  assign instruction_pc    = pc_p1;
  assign instruction_valid = vld_p1;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a 1-cycle synchronous memory model
// preloaded as mem[i] = i + 8'h10.
module tb_instruction_fetch;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       stall;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic [7:0] instruction_address;
  logic [7:0] instruction_data;
  logic [7:0] instruction_out;
  logic [7:0] instruction_pc;
  logic       instruction_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] mem [0:255];

  instruction_fetch #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(64), .RESET_PC(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .instruction_address(instruction_address),
    .instruction_data(instruction_data),
    .instruction_out(instruction_out),
    .instruction_pc(instruction_pc),
    .instruction_valid(instruction_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) instruction_data <= mem[instruction_address];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic en, input logic st, input logic br, input logic [7:0] tgt);
    enable = en;
    stall = st;
    branch_taken = br;
    branch_target = tgt;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({instruction_valid, instruction_pc} !== {1'b0, 8'h00}) begin
      $display("FAIL reset_state got v=%0b pc=%h want v=0 pc=00", instruction_valid, instruction_pc);
      n_fail++;
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    n_cmp++;
    if (instruction_address !== 8'h00) begin
      $display("FAIL reset_addr got %h want 00", instruction_address);
      n_fail++;
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if ({instruction_valid, instruction_pc, instruction_out} !== {1'b1, 8'(i), 8'(i + 8'h10)}) begin
        $display("FAIL seq_%0d got v=%0b pc=%h d=%h want v=1 pc=%h d=%h", i, instruction_valid,
                 instruction_pc, instruction_out, 8'(i), 8'(i + 8'h10));
        n_fail++;
      end
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (instruction_address !== 8'h05) begin
        $display("FAIL stall_addr_%0d got %h want 05", i, instruction_address);
        n_fail++;
      end
      tick();
      n_cmp++;
      if ({instruction_valid, instruction_pc, instruction_out} !== {1'b1, 8'h05, 8'h15}) begin
        $display("FAIL stall_hold_%0d got v=%0b pc=%h d=%h want v=1 pc=05 d=15", i,
                 instruction_valid, instruction_pc, instruction_out);
        n_fail++;
      end
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    n_cmp++;
    if ({instruction_valid, instruction_pc, instruction_out} !== {1'b1, 8'h06, 8'h16}) begin
      $display("FAIL stall_release got v=%0b pc=%h d=%h want v=1 pc=06 d=16",
               instruction_valid, instruction_pc, instruction_out);
      n_fail++;
    end
  endtask

  task automatic test_branch();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) tick();
    n_cmp++;
    if (instruction_pc !== 8'h03) begin
      $display("FAIL branch_setup got pc=%h want 03", instruction_pc);
      n_fail++;
    end
    drive(1'b1, 1'b0, 1'b1, 8'h20);
    n_cmp++;
    if (instruction_address !== 8'h20) begin
      $display("FAIL branch_addr got %h want 20", instruction_address);
      n_fail++;
    end
    tick();
    n_cmp++;
    if ({instruction_valid, instruction_pc, instruction_out} !== {1'b1, 8'h20, 8'h30}) begin
      $display("FAIL branch_first got v=%0b pc=%h d=%h want v=1 pc=20 d=30",
               instruction_valid, instruction_pc, instruction_out);
      n_fail++;
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    n_cmp++;
    if ({instruction_valid, instruction_pc, instruction_out} !== {1'b1, 8'h21, 8'h31}) begin
      $display("FAIL branch_next got v=%0b pc=%h d=%h want v=1 pc=21 d=31",
               instruction_valid, instruction_pc, instruction_out);
      n_fail++;
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b0, 1'b1, 8'h3F);
    tick();
    n_cmp++;
    if ({instruction_pc, instruction_out} !== {8'h3F, 8'h4F}) begin
      $display("FAIL wrap_last got pc=%h d=%h want pc=3f d=4f", instruction_pc, instruction_out);
      n_fail++;
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    n_cmp++;
    if (instruction_address !== 8'h00) begin
      $display("FAIL wrap_addr got %h want 00", instruction_address);
      n_fail++;
    end
    tick();
    n_cmp++;
    if ({instruction_valid, instruction_pc, instruction_out} !== {1'b1, 8'h00, 8'h10}) begin
      $display("FAIL wrap_zero got v=%0b pc=%h d=%h want v=1 pc=00 d=10",
               instruction_valid, instruction_pc, instruction_out);
      n_fail++;
    end
    drive(1'b1, 1'b0, 1'b1, 8'hC5);
    n_cmp++;
    if (instruction_address !== 8'h05) begin
      $display("FAIL mask_addr got %h want 05", instruction_address);
      n_fail++;
    end
    tick();
    n_cmp++;
    if ({instruction_valid, instruction_pc, instruction_out} !== {1'b1, 8'h05, 8'h15}) begin
      $display("FAIL mask_out got v=%0b pc=%h d=%h want v=1 pc=05 d=15",
               instruction_valid, instruction_pc, instruction_out);
      n_fail++;
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    n_cmp++;
    if (instruction_pc !== 8'h06) begin
      $display("FAIL mask_next got pc=%h want 06", instruction_pc);
      n_fail++;
    end
  endtask

  task automatic test_enable();
    drive(1'b1, 1'b0, 1'b1, 8'h09);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      if (i == 1) drive(1'b0, 1'b1, 1'b1, 8'h30);
      n_cmp++;
      if (instruction_address !== 8'h0A) begin
        $display("FAIL dis_addr_%0d got %h want 0a", i, instruction_address);
        n_fail++;
      end
      tick();
      n_cmp++;
      if (instruction_valid !== 1'b0) begin
        $display("FAIL dis_valid_%0d got %0b want 0", i, instruction_valid);
        n_fail++;
      end
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    n_cmp++;
    if ({instruction_valid, instruction_pc, instruction_out} !== {1'b1, 8'h0A, 8'h1A}) begin
      $display("FAIL resume got v=%0b pc=%h d=%h want v=1 pc=0a d=1a",
               instruction_valid, instruction_pc, instruction_out);
      n_fail++;
    end
    // Stall entered while output is invalid must keep it invalid.
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    tick();
    n_cmp++;
    if (instruction_valid !== 1'b0) begin
      $display("FAIL stall_invalid got v=%0b want 0", instruction_valid);
      n_fail++;
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    n_cmp++;
    if ({instruction_valid, instruction_pc} !== {1'b1, 8'h0B}) begin
      $display("FAIL stall_invalid_exit got v=%0b pc=%h want v=1 pc=0b", instruction_valid, instruction_pc);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 1'b0, 1'b1, 8'h0C);
    tick();
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    tick();
    n_cmp++;
    if ({instruction_valid, instruction_pc} !== {1'b1, 8'h0C}) begin
      $display("FAIL pre_reset got v=%0b pc=%h want v=1 pc=0c", instruction_valid, instruction_pc);
      n_fail++;
    end
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 8'h2A);
    tick();
    n_cmp++;
    if ({instruction_valid, instruction_pc} !== {1'b0, 8'h00}) begin
      $display("FAIL reset_stall got v=%0b pc=%h want v=0 pc=00", instruction_valid, instruction_pc);
      n_fail++;
    end
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    n_cmp++;
    if ({instruction_valid, instruction_pc, instruction_out} !== {1'b1, 8'h00, 8'h10}) begin
      $display("FAIL post_reset got v=%0b pc=%h d=%h want v=1 pc=00 d=10",
               instruction_valid, instruction_pc, instruction_out);
      n_fail++;
    end
  endtask

  task automatic test_branch_stall();
    drive(1'b1, 1'b1, 1'b1, 8'h07);
    n_cmp++;
    if (instruction_address !== 8'h07) begin
      $display("FAIL br_stall_addr got %h want 07", instruction_address);
      n_fail++;
    end
    tick();
    n_cmp++;
    if ({instruction_valid, instruction_pc, instruction_out} !== {1'b1, 8'h07, 8'h17}) begin
      $display("FAIL br_stall_out got v=%0b pc=%h d=%h want v=1 pc=07 d=17",
               instruction_valid, instruction_pc, instruction_out);
      n_fail++;
    end
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    tick();
    n_cmp++;
    if ({instruction_pc, instruction_out} !== {8'h07, 8'h17}) begin
      $display("FAIL br_stall_hold got pc=%h d=%h want pc=07 d=17", instruction_pc, instruction_out);
      n_fail++;
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    n_cmp++;
    if ({instruction_valid, instruction_pc, instruction_out} !== {1'b1, 8'h08, 8'h18}) begin
      $display("FAIL br_stall_next got v=%0b pc=%h d=%h want v=1 pc=08 d=18",
               instruction_valid, instruction_pc, instruction_out);
      n_fail++;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 8'h10);
    reset = 1'b1;
    enable = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 8'h00;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_wrap();
    test_enable();
    test_reset_mid_stall();
    test_branch_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
